mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage for the 5-stage RISC-V core, between the execute/memory pipeline register and the memory/writeback register (`M_RB`). It turns the load/store in the M stage into a data-memory bus transaction with a req/ready plus rvalid handshake. It aligns store data and byte strobes, and sign- or zero-extends load data into `mem_rdata_M`. It stalls the pipeline until the access completes.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_ren_M` in 1: load in M stage.
- `mem_wen_M` in 1: store in M stage (never both with `mem_ren_M`).
- `funct3_M` in 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `alu_result_M` in 32: effective byte address.
- `rs2_data_M` in 32: store data.
- `hold_M` in 1: pipeline frozen by another source.
- `flush_M` in 1: kill the M-stage instruction.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: write.
- `dmem_addr` out 32: word address, bits [1:0]=0.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_wstrb` out 4: byte enables, 0 for loads.
- `dmem_ready` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: load data valid, ≥1 cycle after acceptance.
- `dmem_rdata` in 32: load word.
- `mem_rdata_M` out 32: extended load result, captured by `M_RB`.
- `mem_stall_M` out 1: freeze PC and the F/D/E/M registers.
- `misalign_M` out 1: misaligned access, no bus request.

## Operation
- op = `mem_ren_M | mem_wen_M`.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. Such an op raises `misalign_M` combinationally, issues no request, and does not stall.
- Store lanes, off = addr[1:0]:
  - SB: wdata {4{rs2[7:0]}}, strb 0001<<off.
  - SH: wdata {2{rs2[15:0]}}, strb 0011<<off.
  - SW: wdata rs2, strb 1111.
- Load: select byte/half at off from `dmem_rdata`; sign-extend for B/H, zero-extend for BU/HU.
- On issue, addr/we/wdata/strb/funct3/off are latched. In REQ/WAIT_R the bus outputs and extension come from these latches, not the pipeline inputs.
- A raised `dmem_req` is never withdrawn before `dmem_ready`, even on flush. A flushed store that is already requested still commits. A flushed load's data is discarded.
- FSM states:
  - IDLE. If op & !misalign & !flush: drive `dmem_req`. Then:
    - ready & store → DONE if `hold_M`, else IDLE.
    - ready & load → WAIT_R.
    - otherwise → REQ.
  - REQ: hold `dmem_req`. On ready:
    - store → DONE if (`hold_M` & !flush), else IDLE.
    - load → DRAIN if flush seen (now or since issue), else WAIT_R.
  - WAIT_R. If rvalid: capture the extended result to rdata_q, then go to DONE if (`hold_M` & !flush), else IDLE. If flush & !rvalid: → DRAIN.
  - DONE: the op is complete, pipeline frozen. Go to IDLE when `!hold_M` or flush. No new request.
  - DRAIN: no request. Go to IDLE on rvalid; the data is dropped.
- `mem_stall_M` is 1 when:
  - op is present in IDLE and not completing (a load never completes in IDLE; a store completes on ready), or
  - REQ and not (store & ready), or
  - WAIT_R & !rvalid, or
  - DRAIN & op.
- `mem_stall_M` is 0 in DONE.
- `mem_rdata_M` is the extended `dmem_rdata` in a cycle where WAIT_R & rvalid. Otherwise it is rdata_q.

## Timing
- Reset (async, `rst_n`=0): state IDLE, latches and rdata_q 0. `dmem_req`, `dmem_we`, `dmem_wstrb`, `mem_stall_M`, `misalign_M`, and `mem_rdata_M` all read 0 while in reset.
- Best-case latency:
  - Store: 1 cycle (ready in the issue cycle, no stall).
  - Load: issue cycle plus ≥1 cycle; `mem_rdata_M` is valid in the rvalid cycle and `M_RB` captures it at the following edge.
- Simultaneous events:
  - flush + rvalid in WAIT_R → IDLE, data dropped.
  - flush + ready in REQ for a load → DRAIN.
  - `hold_M` in IDLE does not block issue.
- Reset mid-transaction: abandons the access. The memory side is reset by the same `rst_n`.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: IDLE/REQ/WAIT_R/DONE/DRAIN.
- Sub-module `lsu_align` (combinational): store lane/strobe generation, load select/extend, and misalign detection.

## Test plan
- SB to 0x1003, rs2=0x000000A5, ready in the issue cycle → wdata 0xA5A5A5A5, strb 1000, addr 0x1000, no stall.
- LH at 0x2002; ready after 2 cycles; rvalid 3 cycles later with rdata 0x8001_1234 → `mem_rdata_M`=0xFFFF8001, stall exactly until the rvalid cycle.
- LW at 0x3001 → `misalign_M`=1, `dmem_req`=0, no stall.
- LBU at 0x4001, rvalid with rdata 0x0000F100 while `hold_M`=1 for 2 more cycles → DONE; `mem_rdata_M` holds 0xF1; no second request.
- LW issued, flush in WAIT_R, new SW in M → DRAIN, SW stalled with no request until rvalid, then SW issues next cycle.
- Assert `rst_n`=0 during REQ → `dmem_req` drops asynchronously, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data-memory access path.
package mem_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned STRB_W = XLEN / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT_R = 3'd2,
      DONE   = 3'd3,
      DRAIN  = 3'd4
   } state_e;

   // Request snapshot taken at issue; drives the bus and load extension afterwards.
   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic              we;
      logic [XLEN-1:0]   wdata;
      logic [STRB_W-1:0] wstrb;
      logic [2:0]        funct3;
      logic [1:0]        off;
   } mem_req_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: req/ready request channel plus rvalid read-data return.
interface mem_access_stage_if;
   import mem_pkg::*;

   logic              dmem_req;
   logic              dmem_we;
   logic [XLEN-1:0]   dmem_addr;
   logic [XLEN-1:0]   dmem_wdata;
   logic [STRB_W-1:0] dmem_wstrb;
   logic              dmem_ready;
   logic              dmem_rvalid;
   logic [XLEN-1:0]   dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ready, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ready, dmem_rvalid, dmem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication/strobes, load select/extend, misalign check.
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]        st_funct3,
   input  logic [1:0]        st_off,
   input  logic [XLEN-1:0]   st_data,
   output logic [XLEN-1:0]   st_wdata_c,
   output logic [STRB_W-1:0] st_wstrb_c,
   output logic              misalign_c,
   input  logic [2:0]        ld_funct3,
   input  logic [1:0]        ld_off,
   input  logic [XLEN-1:0]   ld_word,
   output logic [XLEN-1:0]   ld_data_c
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_wdata_c = st_data;
      st_wstrb_c = 4'b1111;
      case (st_funct3)
         F3_B, F3_BU: begin
            st_wdata_c = {4{st_data[7:0]}};
            st_wstrb_c = 4'b0001 << st_off;
         end
         F3_H, F3_HU: begin
            st_wdata_c = {2{st_data[15:0]}};
            st_wstrb_c = 4'b0011 << st_off;
         end
         default: ;
      endcase
   end

   always_comb begin
      misalign_c = 1'b0;
      if ((st_funct3 == F3_H) || (st_funct3 == F3_HU)) misalign_c = st_off[0];
      else if (st_funct3 == F3_W)                        misalign_c = |st_off;
   end

   always_comb begin
      ld_byte = ld_word[7:0];
      case (ld_off)
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         2'd3:    ld_byte = ld_word[31:24];
         default: ld_byte = ld_word[7:0];
      endcase
      ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

      ld_data_c = ld_word;
      case (ld_funct3)
         F3_B:    ld_data_c = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data_c = {24'd0, ld_byte};
         F3_H:    ld_data_c = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data_c = {16'd0, ld_half};
         default: ld_data_c = ld_word;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// M-stage load/store unit: issues one data-memory transaction per op and stalls until it completes.
module mem_access_stage
   import mem_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mem_ren_M,
   input  logic                mem_wen_M,
   input  logic [2:0]          funct3_M,
   input  logic [XLEN-1:0]     alu_result_M,
   input  logic [XLEN-1:0]     rs2_data_M,
   input  logic                hold_M,
   input  logic                flush_M,
   mem_access_stage_if.master  dmem,
   output logic [XLEN-1:0]     mem_rdata_M,
   output logic                mem_stall_M,
   output logic                misalign_M
);

   state_e          state_q, state_d;
   mem_req_t        req_q, req_d;
   logic            flushed_q, flushed_d;
   logic [XLEN-1:0] rdata_q, rdata_d;

   logic              op;
   logic              issue;
   logic              in_req;
   logic              stall;
   logic              mis;
   logic [XLEN-1:0]   st_wdata;
   logic [STRB_W-1:0] st_wstrb;
   logic [XLEN-1:0]   ld_ext;

   lsu_align u_align (
      .st_funct3  (funct3_M),
      .st_off     (alu_result_M[1:0]),
      .st_data    (rs2_data_M),
      .st_wdata_c (st_wdata),
      .st_wstrb_c (st_wstrb),
      .misalign_c (mis),
      .ld_funct3  (req_q.funct3),
      .ld_off     (req_q.off),
      .ld_word    (dmem.dmem_rdata),
      .ld_data_c  (ld_ext)
   );

   assign op     = mem_ren_M | mem_wen_M;
   assign issue  = (state_q == IDLE) & op & ~mis & ~flush_M;
   assign in_req = (state_q == REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         req_q     <= '0;
         flushed_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         flushed_q <= flushed_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next state; a raised request is held until ready regardless of flush.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      flushed_d = flushed_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (issue) begin
               req_d = '{addr:   {alu_result_M[XLEN-1:2], 2'b00},
                         we:     mem_wen_M,
                         wdata:  st_wdata,
                         wstrb:  mem_wen_M ? st_wstrb : STRB_W'(0),
                         funct3: funct3_M,
                         off:    alu_result_M[1:0]};
               flushed_d = 1'b0;
               if (dmem.dmem_ready && mem_wen_M) state_d = hold_M ? DONE : IDLE;
               else if (dmem.dmem_ready)          state_d = WAIT_R;
               else                               state_d = REQ;
            end
         end
         REQ: begin
            if (flush_M) flushed_d = 1'b1;
            if (dmem.dmem_ready) begin
               if (req_q.we) state_d = (hold_M && !flush_M) ? DONE : IDLE;
               else          state_d = (flush_M || flushed_q) ? DRAIN : WAIT_R;
            end
         end
         WAIT_R: begin
            if (dmem.dmem_rvalid) begin
               if (!flush_M) rdata_d = ld_ext;
               state_d = (hold_M && !flush_M) ? DONE : IDLE;
            end else if (flush_M) begin
               state_d = DRAIN;
            end
         end
         DONE:    if (!hold_M || flush_M) state_d = IDLE;
         DRAIN:   if (dmem.dmem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      case (state_q)
         IDLE:    stall = op & ~mis & ~flush_M & ~(mem_wen_M & dmem.dmem_ready);
         REQ:     stall = ~(req_q.we & dmem.dmem_ready);
         WAIT_R:  stall = ~dmem.dmem_rvalid;
         DRAIN:   stall = op;
         default: stall = 1'b0;
      endcase
   end

   // Issue-cycle bus fields come from the pipeline; afterwards from the snapshot.
   always_comb begin
      dmem.dmem_req   = rst_n & (issue | in_req);
      dmem.dmem_we    = dmem.dmem_req & (in_req ? req_q.we : mem_wen_M);
      dmem.dmem_addr  = in_req ? req_q.addr : {alu_result_M[XLEN-1:2], 2'b00};
      dmem.dmem_wdata = in_req ? req_q.wdata : st_wdata;
      dmem.dmem_wstrb = dmem.dmem_we ? (in_req ? req_q.wstrb : st_wstrb) : STRB_W'(0);
      mem_stall_M     = rst_n & stall;
      misalign_M      = rst_n & op & mis;
      mem_rdata_M     = ((state_q == WAIT_R) && dmem.dmem_rvalid) ? ld_ext : rdata_q;
   end

endmodule
